// File: rtl/des_pkg.sv
// Shared DES constants: permutation tables, S-boxes, decrypt key-rotation schedule, FSM state type,
// and the permutation/substitution helpers used by the round and the top.
package des_pkg;

  localparam int DES_BLK_W = 64;

  typedef enum logic [1:0] {IDLE, ROUND, FINAL, DONE} state_t;

  // Table entries are FIPS 46-3 bit numbers: 1 = MSB of the source vector.
  localparam int IP_T [64] = '{
    58, 50, 42, 34, 26, 18, 10,  2, 60, 52, 44, 36, 28, 20, 12,  4,
    62, 54, 46, 38, 30, 22, 14,  6, 64, 56, 48, 40, 32, 24, 16,  8,
    57, 49, 41, 33, 25, 17,  9,  1, 59, 51, 43, 35, 27, 19, 11,  3,
    61, 53, 45, 37, 29, 21, 13,  5, 63, 55, 47, 39, 31, 23, 15,  7};

  localparam int FP_T [64] = '{
    40,  8, 48, 16, 56, 24, 64, 32, 39,  7, 47, 15, 55, 23, 63, 31,
    38,  6, 46, 14, 54, 22, 62, 30, 37,  5, 45, 13, 53, 21, 61, 29,
    36,  4, 44, 12, 52, 20, 60, 28, 35,  3, 43, 11, 51, 19, 59, 27,
    34,  2, 42, 10, 50, 18, 58, 26, 33,  1, 41,  9, 49, 17, 57, 25};

  localparam int E_T [48] = '{
    32,  1,  2,  3,  4,  5,  4,  5,  6,  7,  8,  9,
     8,  9, 10, 11, 12, 13, 12, 13, 14, 15, 16, 17,
    16, 17, 18, 19, 20, 21, 20, 21, 22, 23, 24, 25,
    24, 25, 26, 27, 28, 29, 28, 29, 30, 31, 32,  1};

  localparam int P_T [32] = '{
    16,  7, 20, 21, 29, 12, 28, 17,  1, 15, 23, 26,  5, 18, 31, 10,
     2,  8, 24, 14, 32, 27,  3,  9, 19, 13, 30,  6, 22, 11,  4, 25};

  localparam int PC1_T [56] = '{
    57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4};

  localparam int PC2_T [48] = '{
    14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32};

  // Indexed by {b5,b0,b4..b1} of the 6-bit group, i.e. row*16+col.
  localparam logic [3:0] SBOX [8][64] = '{
    '{14,4,13,1,2,15,11,8,3,10,6,12,5,9,0,7, 0,15,7,4,14,2,13,1,10,6,12,11,9,5,3,8,
      4,1,14,8,13,6,2,11,15,12,9,7,3,10,5,0, 15,12,8,2,4,9,1,7,5,11,3,14,10,0,6,13},
    '{15,1,8,14,6,11,3,4,9,7,2,13,12,0,5,10, 3,13,4,7,15,2,8,14,12,0,1,10,6,9,11,5,
      0,14,7,11,10,4,13,1,5,8,12,6,9,3,2,15, 13,8,10,1,3,15,4,2,11,6,7,12,0,5,14,9},
    '{10,0,9,14,6,3,15,5,1,13,12,7,11,4,2,8, 13,7,0,9,3,4,6,10,2,8,5,14,12,11,15,1,
      13,6,4,9,8,15,3,0,11,1,2,12,5,10,14,7, 1,10,13,0,6,9,8,7,4,15,14,3,11,5,2,12},
    '{7,13,14,3,0,6,9,10,1,2,8,5,11,12,4,15, 13,8,11,5,6,15,0,3,4,7,2,12,1,10,14,9,
      10,6,9,0,12,11,7,13,15,1,3,14,5,2,8,4, 3,15,0,6,10,1,13,8,9,4,5,11,12,7,2,14},
    '{2,12,4,1,7,10,11,6,8,5,3,15,13,0,14,9, 14,11,2,12,4,7,13,1,5,0,15,10,3,9,8,6,
      4,2,1,11,10,13,7,8,15,9,12,5,6,3,0,14, 11,8,12,7,1,14,2,13,6,15,0,9,10,4,5,3},
    '{12,1,10,15,9,2,6,8,0,13,3,4,14,7,5,11, 10,15,4,2,7,12,9,5,6,1,13,14,0,11,3,8,
      9,14,15,5,2,8,12,3,7,0,4,10,1,13,11,6, 4,3,2,12,9,5,15,10,11,14,1,7,6,0,8,13},
    '{4,11,2,14,15,0,8,13,3,12,9,7,5,10,6,1, 13,0,11,7,4,9,1,10,14,3,5,12,2,15,8,6,
      1,4,11,13,12,3,7,14,10,15,6,8,0,5,9,2, 6,11,13,8,1,4,10,7,9,5,0,15,14,2,3,12},
    '{13,2,8,4,6,15,11,1,10,9,3,14,5,0,12,7, 1,15,13,8,10,3,7,4,12,5,6,11,0,14,9,2,
      7,11,4,1,9,12,14,2,0,6,10,13,15,3,5,8, 2,1,14,7,4,10,8,13,15,12,9,0,3,5,6,11}};

  // Right-rotate applied to C/D after decrypt round rnd; entry 15 is unused (C/D reload follows).
  localparam logic [1:0] ROT_R [16] = '{1,2,2,2,2,2,2,1,2,2,2,2,2,2,1,0};

  function automatic logic [63:0] ip_perm(input logic [63:0] x);
    logic [63:0] y;
    for (int i = 0; i < 64; i++) y[63-i] = x[64-IP_T[i]];
    return y;
  endfunction

  function automatic logic [63:0] fp_perm(input logic [63:0] x);
    logic [63:0] y;
    for (int i = 0; i < 64; i++) y[63-i] = x[64-FP_T[i]];
    return y;
  endfunction

  function automatic logic [55:0] pc1_perm(input logic [63:0] x);
    logic [55:0] y;
    for (int i = 0; i < 56; i++) y[55-i] = x[64-PC1_T[i]];
    return y;
  endfunction

  function automatic logic [47:0] pc2_perm(input logic [55:0] x);
    logic [47:0] y;
    for (int i = 0; i < 48; i++) y[47-i] = x[56-PC2_T[i]];
    return y;
  endfunction

  function automatic logic [47:0] e_expand(input logic [31:0] x);
    logic [47:0] y;
    for (int i = 0; i < 48; i++) y[47-i] = x[32-E_T[i]];
    return y;
  endfunction

  function automatic logic [31:0] p_perm(input logic [31:0] x);
    logic [31:0] y;
    for (int i = 0; i < 32; i++) y[31-i] = x[32-P_T[i]];
    return y;
  endfunction

  function automatic logic [31:0] sbox_sub(input logic [47:0] x);
    logic [31:0] y;
    logic [5:0]  b;
    for (int s = 0; s < 8; s++) begin
      b = x[47-6*s -: 6];
      y[31-4*s -: 4] = SBOX[s][{b[5], b[0], b[4:1]}];
    end
    return y;
  endfunction

  function automatic logic [27:0] rot_r28(input logic [27:0] x, input logic [1:0] n);
    case (n)
      2'd1:    return {x[0], x[27:1]};
      2'd2:    return {x[1:0], x[27:2]};
      default: return x;
    endcase
  endfunction

endpackage

// File: rtl/des_round.sv
// One combinational DES Feistel round: L' = R, R' = L ^ P(S(E(R) ^ subkey)).
module des_round
  import des_pkg::*;
(
  input  logic [31:0] l,
  input  logic [31:0] r,
  input  logic [47:0] subkey,
  output logic [31:0] l_next,
  output logic [31:0] r_next
);

  logic [31:0] f;

  assign f      = p_perm(sbox_sub(e_expand(r) ^ subkey));
  assign l_next = r;
  assign r_next = l ^ f;

endmodule

// File: rtl/des_decrypt_seq.sv
// Iterative multi-block DES ECB decryptor: one round per clock, blocks processed low to high,
// with valid/ready handshakes on the ciphertext and plaintext sides.
module des_decrypt_seq
  import des_pkg::*;
#(
  parameter int NBLK   = 2,
  parameter int ROUNDS = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [DES_BLK_W*NBLK-1:0] cipher,
  input  logic [127:0]            key,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [DES_BLK_W*NBLK-1:0] plain,
  output logic                    busy
);

  localparam int W  = DES_BLK_W * NBLK;
  localparam int BW = (NBLK > 1) ? $clog2(NBLK) : 1;

  state_t          state, state_next;
  logic [W-1:0]    cipher_q, plain_q;
  logic [55:0]     key_q;
  logic [27:0]     c_q, d_q;
  logic [31:0]     l_q, r_q, l_next, r_next;
  logic [3:0]      rnd_q;
  logic [BW-1:0]   blk_q, blk_inc;
  logic [63:0]     next_blk_data;
  logic            last_rnd, last_blk;
  logic            unused_key_hi;

  assign unused_key_hi = ^key[127:64];

  assign last_rnd = (rnd_q == 4'(ROUNDS - 1));
  assign last_blk = (blk_q == BW'(NBLK - 1));
  assign blk_inc  = blk_q + 1'b1;

  des_round u_round (
    .l      (l_q),
    .r      (r_q),
    .subkey (pc2_perm({c_q, d_q})),
    .l_next (l_next),
    .r_next (r_next)
  );

  always_comb begin
    next_blk_data = '0;
    if (!last_blk) next_blk_data = cipher_q[DES_BLK_W*blk_inc +: DES_BLK_W];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // NOTE: every path assigns state_next because of the default on the first line; no latch is inferred.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (in_valid)  state_next = ROUND;
      ROUND:   if (last_rnd)  state_next = FINAL;
      FINAL:   state_next = last_blk ? DONE : ROUND;
      DONE:    if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // NOTE: the datapath is reset along with the FSM so an aborted word leaves no trace and plain reads 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cipher_q <= '0;
      plain_q  <= '0;
      key_q    <= '0;
      c_q      <= '0;
      d_q      <= '0;
      l_q      <= '0;
      r_q      <= '0;
      rnd_q    <= '0;
      blk_q    <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register here samples pre-edge values of the others.
      case (state)
        IDLE: if (in_valid) begin
          cipher_q     <= cipher;
          key_q        <= pc1_perm(key[63:0]);
          {c_q, d_q}   <= pc1_perm(key[63:0]);
          {l_q, r_q}   <= ip_perm(cipher[63:0]);
          rnd_q        <= '0;
          blk_q        <= '0;
        end
        ROUND: begin
          l_q   <= l_next;
          r_q   <= r_next;
          rnd_q <= rnd_q + 4'd1;
          if (!last_rnd) begin
            c_q <= rot_r28(c_q, ROT_R[rnd_q]);
            d_q <= rot_r28(d_q, ROT_R[rnd_q]);
          end
        end
        FINAL: begin
          // R/L are swapped back before FP to undo the last round's half exchange.
          plain_q[DES_BLK_W*blk_q +: DES_BLK_W] <= fp_perm({r_q, l_q});
          rnd_q <= '0;
          if (!last_blk) begin
            blk_q      <= blk_inc;
            {l_q, r_q} <= ip_perm(next_blk_data);
            {c_q, d_q} <= key_q;
          end
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (state == IDLE);
  assign busy      = (state != IDLE);
  assign out_valid = (state == DONE);
  assign plain     = plain_q;

endmodule

// File: tb/tb_des_decrypt_seq.sv
// Directed bench for des_decrypt_seq: reset, known-answer vectors, model round trip,
// back-pressure and back-to-back throughput.
module tb_des_decrypt_seq;
  import des_pkg::*;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] cipher;
  logic [127:0] key;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] plain;
  logic         busy;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int acc_cnt = 0;
  logic acc_seen, hs_seen;

  localparam int LSH [16] = '{1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1};
  localparam logic [63:0] PAR_MASK = 64'h0101010101010101;

  des_decrypt_seq dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .cipher    (cipher),
    .key       (key),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .plain     (plain),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  // Records which handshakes the coming edge completes, then steps past it.
  task automatic tick();
    acc_seen = in_valid & in_ready;
    hs_seen  = out_valid & out_ready;
    @(posedge clk);
    #1;
    cyc++;
    if (acc_seen) acc_cnt++;
  endtask

  // Reference DES with a forward (left-shift) key schedule; dec selects K16..K1.
  function automatic logic [63:0] des_model(input logic [63:0] blk, input logic [63:0] k, input bit dec);
    logic [55:0] cd;
    logic [27:0] c, d;
    logic [47:0] sk [16];
    logic [63:0] x, y, o;
    logic [31:0] l, r, t, f, so;
    logic [47:0] e;
    logic [5:0]  b;
    for (int i = 0; i < 56; i++) cd[55-i] = k[64-PC1_T[i]];
    c = cd[55:28];
    d = cd[27:0];
    for (int n = 0; n < 16; n++) begin
      for (int j = 0; j < LSH[n]; j++) begin
        c = {c[26:0], c[27]};
        d = {d[26:0], d[27]};
      end
      cd = {c, d};
      for (int j = 0; j < 48; j++) sk[n][47-j] = cd[56-PC2_T[j]];
    end
    for (int i = 0; i < 64; i++) x[63-i] = blk[64-IP_T[i]];
    l = x[63:32];
    r = x[31:0];
    for (int n = 0; n < 16; n++) begin
      for (int j = 0; j < 48; j++) e[47-j] = r[32-E_T[j]];
      e = e ^ (dec ? sk[15-n] : sk[n]);
      for (int s = 0; s < 8; s++) begin
        b = e[47-6*s -: 6];
        so[31-4*s -: 4] = SBOX[s][{b[5], b[0], b[4:1]}];
      end
      for (int j = 0; j < 32; j++) f[31-j] = so[32-P_T[j]];
      t = r;
      r = l ^ f;
      l = t;
    end
    y = {r, l};
    for (int i = 0; i < 64; i++) o[63-i] = y[64-FP_T[i]];
    return o;
  endfunction

  // Offers one word, takes the result with out_ready=1. lat = edges from accept to output handshake.
  task automatic send_word(input logic [127:0] c, input logic [127:0] k,
                           output logic [127:0] res, output int lat);
    int n;
    cipher = c; key = k; in_valid = 1'b1; out_ready = 1'b1;
    n = 0;
    while (!in_ready && n < 200) begin tick(); n++; end
    tick();
    in_valid = 1'b0; cipher = ~c; key = ~k;
    n = 0;
    while (!out_valid && n < 200) begin tick(); n++; end
    check("out_valid_timeout", n < 200, 1);
    lat = n + 1;
    res = plain;
    tick();
  endtask

  initial begin
    logic [127:0] res, held, p, c, k;
    logic [127:0] w_plain [4];
    logic [127:0] w_ciph  [4];
    int           stall   [4];
    int           t_acc   [4];
    int           lat, n, acc0;
    logic         seen;
    logic [63:0]  k64;

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; cipher = '0; key = '0;
    #1;
    check("reset_flags", {in_ready, out_valid, busy}, 3'b100);
    check("reset_plain", plain, '0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    tick();
    check("idle_after_reset", {in_ready, out_valid, busy}, 3'b100);

    // Model sanity against the classic FIPS example.
    check("model_kat", des_model(64'h0123456789ABCDEF, 64'h133457799BBCDFF1, 1'b0), 64'h85E813540F0AB405);

    // Abort mid-ROUND: no result may ever appear.
    cipher = {2{64'h85E813540F0AB405}}; key = {64'h0, 64'h133457799BBCDFF1}; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (5) tick();
    check("busy_mid_round", busy, 1);
    rst_n = 1'b0;
    #1;
    check("abort_flags", {in_ready, out_valid, busy}, 3'b100);
    check("abort_plain", plain, '0);
    tick();
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (50) begin tick(); if (out_valid) seen = 1'b1; end
    check("no_out_after_abort", seen, 0);

    // Known answer 1, with junk in the ignored key half; handshake at edge T+35.
    send_word({2{64'h85E813540F0AB405}}, {64'hDEADBEEFCAFEF00D, 64'h133457799BBCDFF1}, res, lat);
    check("kat1_plain", res, {2{64'h0123456789ABCDEF}});
    check("kat1_latency", lat, 35);
    check("kat1_post_hs", {in_ready, out_valid, busy}, 3'b100);

    // Known answer 2: upper block fixed, lower block against the model.
    send_word({64'h0, 64'h85E813540F0AB405}, {64'h0, 64'h0E329232EA6D0D73}, res, lat);
    check("kat2_upper", res[127:64], 64'h8787878787878787);
    check("kat2_lower", res[63:0], des_model(64'h85E813540F0AB405, 64'h0E329232EA6D0D73, 1'b1));

    // Back-pressure: output held 20 cycles while in_valid pulses are offered.
    cipher = {2{64'h85E813540F0AB405}}; key = {64'h0, 64'h133457799BBCDFF1};
    in_valid = 1'b1; out_ready = 1'b0;
    tick();
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 200) begin tick(); n++; end
    check("bp_out_valid", out_valid, 1);
    held = plain;
    for (int i = 0; i < 20; i++) begin
      in_valid = i[0];
      cipher = {$urandom, $urandom, $urandom, $urandom};
      tick();
      check("bp_plain_stable", plain, held);
      check("bp_flags", {in_ready, out_valid, busy}, 3'b011);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    tick();
    check("bp_one_handshake", hs_seen, 1);
    check("bp_ready_next", {in_ready, out_valid}, 2'b10);
    check("bp_plain_value", plain, {2{64'h0123456789ABCDEF}});
    seen = 1'b0;
    repeat (40) begin tick(); if (busy || out_valid) seen = 1'b1; end
    check("bp_pulses_ignored", seen, 0);

    // Round trip through the reference encryptor, with random parity bits in the decrypt key.
    for (int w = 0; w < 1000; w++) begin
      k64 = {$urandom, $urandom};
      p   = {$urandom, $urandom, $urandom, $urandom};
      c   = {des_model(p[127:64], k64, 1'b0), des_model(p[63:0], k64, 1'b0)};
      k   = {$urandom, $urandom, k64 ^ ({$urandom, $urandom} & PAR_MASK)};
      send_word(c, k, res, lat);
      check("roundtrip", res, p);
    end

    // Back-to-back with in_valid held high and a few output stalls.
    k64 = 64'h0E329232EA6D0D73;
    stall = '{0, 4, 0, 7};
    for (int i = 0; i < 4; i++) begin
      w_plain[i] = {$urandom, $urandom, $urandom, $urandom};
      w_ciph[i]  = {des_model(w_plain[i][127:64], k64, 1'b0), des_model(w_plain[i][63:0], k64, 1'b0)};
    end
    acc0 = acc_cnt;
    key = {64'h0, k64}; cipher = w_ciph[0]; in_valid = 1'b1; out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("b2b_accept", acc_seen, 1);
      t_acc[i] = cyc;
      if (i > 0) check("b2b_interval", t_acc[i] - t_acc[i-1], 36 + stall[i-1]);
      if (i < 3) cipher = w_ciph[i+1];
      else       in_valid = 1'b0;
      n = 0;
      while (!out_valid && n < 200) begin tick(); n++; end
      check("b2b_timeout", n < 200, 1);
      out_ready = 1'b0;
      repeat (stall[i]) tick();
      out_ready = 1'b1;
      res = plain;
      tick();
      check("b2b_plain", res, w_plain[i]);
    end
    seen = 1'b0;
    repeat (40) begin tick(); if (out_valid) seen = 1'b1; end
    check("b2b_no_extra", seen, 0);
    check("b2b_accept_count", acc_cnt - acc0, 4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
